// File: rtl/alt_multi_gather_pkg.sv
// alt_multi_gather_pkg: shared types and sizing helper for the word-to-vector gatherer.
package alt_multi_gather_pkg;
    typedef enum logic {FILL, STALL} gather_state_e;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/alt_multi_gather_if.sv
// alt_multi_gather_if: serial valid-ready input and vector valid-yumi output of the gatherer.
interface alt_multi_gather_if import alt_multi_gather_pkg::*; #(
    parameter int width_p     = 8,
    parameter int dequeue_n   = 4,
    parameter int cnt_width_p = cnt_width(dequeue_n)
);
    logic                              valid_i;
    logic [width_p-1:0]                data_i;
    logic                              ready_o;
    logic                              flush_i;
    logic                              valid_o;
    logic [dequeue_n-1:0][width_p-1:0] data_o;
    logic [cnt_width_p-1:0]            valid_count_o;
    logic                              yumi_i;
    logic [cnt_width_p-1:0]            fill_o;

    modport slave (
        input  valid_i, data_i, flush_i, yumi_i,
        output ready_o, valid_o, data_o, valid_count_o, fill_o
    );

    modport master (
        output valid_i, data_i, flush_i, yumi_i,
        input  ready_o, valid_o, data_o, valid_count_o, fill_o
    );
endinterface

// File: rtl/alt_multi_gather_out_reg.sv
// alt_multi_gather_out_reg: one-entry valid-yumi vector register; a load wins over a same-edge yumi.
module alt_multi_gather_out_reg #(
    parameter int width_p   = 8,
    parameter int dequeue_n = 4,
    parameter int cw        = 3
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              load,
    input  logic                              yumi,
    input  logic [dequeue_n-1:0][width_p-1:0] next_data,
    input  logic [cw-1:0]                     next_count,
    output logic                              valid,
    output logic [dequeue_n-1:0][width_p-1:0] data,
    output logic [cw-1:0]                     count
);
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            valid <= 1'b0;
            data  <= '0;
            count <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= next_data;
            count <= next_count;
        end else if (yumi) begin
            valid <= 1'b0;
        end
endmodule

// File: rtl/alt_multi_gather.sv
// alt_multi_gather: packs dequeue_n serial words (or a flushed partial group, zero padded)
// into one vector, with a collection stage double-buffered behind the output register.
module alt_multi_gather import alt_multi_gather_pkg::*; #(
    parameter int width_p   = 8,
    parameter int dequeue_n = 4
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    alt_multi_gather_if.slave   bus
);
    localparam int cw = cnt_width(dequeue_n);

    gather_state_e                     state, state_n;
    logic [dequeue_n-1:0][width_p-1:0] coll, vec;
    logic [cw-1:0]                     fill, fill_n, n, count;
    logic                              live, ready, acc, close, out_free, load;

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            state <= FILL;
            fill  <= '0;
            coll  <= '0;
            live  <= 1'b0;
        end else begin
            state <= state_n;
            fill  <= fill_n;
            live  <= 1'b1;
            if (acc || close) coll <= vec;
        end

    // In STALL the collection already holds the closed, zero-padded vector.
    always_comb begin
        vec      = '0;
        ready    = live && state == FILL;
        acc      = bus.valid_i && ready;
        n        = fill + cw'(acc);
        close    = state == FILL && n != '0 && (n == cw'(dequeue_n) || bus.flush_i);
        out_free = !bus.valid_o || bus.yumi_i;
        load     = (close || state == STALL) && out_free;
        count    = state == STALL ? fill : n;
        state_n  = (close && !out_free) ? STALL : (state == STALL && out_free) ? FILL : state;
        fill_n   = load ? '0 : state == FILL ? n : fill;
        for (int i = 0; i < dequeue_n; i++)
            vec[i] = (state == STALL || i < int'(fill)) ? coll[i] :
                     (i == int'(fill) && acc) ? bus.data_i : '0;
    end

    assign bus.ready_o = ready;
    assign bus.fill_o  = fill;

    alt_multi_gather_out_reg #(.width_p(width_p), .dequeue_n(dequeue_n), .cw(cw)) out_reg (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .load       (load),
        .yumi       (bus.yumi_i),
        .next_data  (vec),
        .next_count (count),
        .valid      (bus.valid_o),
        .data       (bus.data_o),
        .count      (bus.valid_count_o)
    );
endmodule

// File: tb/tb_alt_multi_gather.sv
// tb_alt_multi_gather: directed cases plus a randomized run against a queue-based vector model.
module tb_alt_multi_gather;
    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        logic [N*W-1:0] d;
        int             c;
    } vec_s;

    logic clk_i = 1'b0;
    logic reset_n_i = 1'b0;
    int   total = 0;
    int   bad = 0;

    alt_multi_gather_if #(.width_p(W), .dequeue_n(N)) bus();

    alt_multi_gather #(.width_p(W), .dequeue_n(N)) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i)
        if (reset_n_i) assert (!(bus.yumi_i && !bus.valid_o)) else $error("yumi asserted without valid_o");

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic f, input logic y);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.flush_i = f;
        bus.yumi_i  = y;
    endtask

    task automatic word(input logic [W-1:0] d);
        drive(1'b1, d, 1'b0, 1'b0);
        tick();
    endtask

    vec_s             q[$];
    logic [W-1:0]     part[$];
    int               sent, delivered, cyc, wt;
    logic             v, f, y;

    initial begin
        drive(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk_i);
        chk("rst_valid", bus.valid_o, 0);
        chk("rst_data", bus.data_o, 0);
        chk("rst_count", bus.valid_count_o, 0);
        chk("rst_fill", bus.fill_o, 0);
        chk("rst_ready", bus.ready_o, 0);
        reset_n_i = 1'b1;
        tick();
        chk("ready_after_rst", bus.ready_o, 1);

        for (int w = 1; w <= 4; w++) word(W'(w));
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t1_valid", bus.valid_o, 1);
        chk("t1_data", bus.data_o, 32'h04030201);
        chk("t1_count", bus.valid_count_o, 4);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        chk("t1_one_cycle", bus.valid_o, 0);

        for (int w = 1; w <= 8; w++) word(W'(w));
        chk("t2_held", bus.data_o, 32'h04030201);
        chk("t2_ready_low", bus.ready_o, 0);
        chk("t2_fill", bus.fill_o, 4);
        drive(1'b1, 8'd9, 1'b0, 1'b0);
        tick();
        chk("t2_nine_blocked", bus.fill_o, 4);
        chk("t2_still_held", bus.data_o, 32'h04030201);
        drive(1'b1, 8'd9, 1'b0, 1'b1);
        tick();
        chk("t2_second", bus.data_o, 32'h08070605);
        chk("t2_valid", bus.valid_o, 1);
        chk("t2_ready_back", bus.ready_o, 1);
        chk("t2_fill0", bus.fill_o, 0);
        drive(1'b1, 8'd9, 1'b0, 1'b0);
        tick();
        chk("t2_nine_taken", bus.fill_o, 1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("t2_flush9", bus.data_o, 32'h00000009);
        chk("t2_flush9_cnt", bus.valid_count_o, 1);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();

        word(8'h0A);
        word(8'h0B);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("t3_data", bus.data_o, 32'h00000B0A);
        chk("t3_count", bus.valid_count_o, 2);
        chk("t3_fill", bus.fill_o, 0);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        chk("t3_empty_flush", bus.valid_o, 0);

        word(8'h0A);
        word(8'h0B);
        drive(1'b1, 8'h0C, 1'b1, 1'b0);
        tick();
        chk("t4_data", bus.data_o, 32'h000C0B0A);
        chk("t4_count", bus.valid_count_o, 3);
        chk("t4_fill", bus.fill_o, 0);
        drive(1'b0, '0, 1'b0, 1'b1);
        tick();

        for (int w = 1; w <= 7; w++) word(W'(w));
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t5_pre_fill", bus.fill_o, 3);
        #2 reset_n_i = 1'b0;
        #1;
        chk("t5_async_valid", bus.valid_o, 0);
        chk("t5_async_fill", bus.fill_o, 0);
        chk("t5_async_ready", bus.ready_o, 0);
        @(negedge clk_i);
        reset_n_i = 1'b1;
        tick();
        for (int w = 5; w <= 8; w++) word(W'(w));
        drive(1'b0, '0, 1'b0, 1'b0);
        chk("t5_vec", bus.data_o, 32'h08070605);
        chk("t5_count", bus.valid_count_o, 4);

        reset_n_i = 1'b0;
        tick();
        reset_n_i = 1'b1;
        tick();
        sent = 0;
        delivered = 0;
        cyc = 0;
        wt = $urandom_range(0, 5);
        while ((sent < 256 || part.size() > 0 || q.size() > 0) && cyc < 20000) begin
            cyc++;
            chk("r_valid", bus.valid_o, q.size() > 0);
            chk("r_ready", bus.ready_o, q.size() < 2);
            if (bus.ready_o) chk("r_fill", bus.fill_o, part.size());
            v = sent < 256 && $urandom_range(0, 3) != 0;
            f = sent < 256 ? $urandom_range(0, 9) == 0 : part.size() > 0;
            y = 1'b0;
            if (bus.valid_o) begin
                if (wt == 0) begin
                    y = 1'b1;
                    wt = $urandom_range(0, 5);
                end else wt--;
            end
            drive(v, W'($urandom), f, y);
            if (y) begin
                chk("r_data", bus.data_o, q[0].d);
                chk("r_count", bus.valid_count_o, q[0].c);
                delivered += q[0].c;
                void'(q.pop_front());
            end
            if (v && bus.ready_o) begin
                part.push_back(bus.data_i);
                sent++;
            end
            if (part.size() == N || (f && part.size() > 0)) begin
                vec_s e;
                e.d = '0;
                foreach (part[i]) e.d[i*W +: W] = part[i];
                e.c = part.size();
                q.push_back(e);
                part = {};
            end
            tick();
        end
        chk("r_timeout", cyc < 20000, 1);
        chk("r_delivered", delivered, 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
